latch_bank_writer: RTL and testbench
====================================

Name: latch_bank_writer

Overview:
- Upstream control stage for a bank of gated D latches (d/enable/q/notq cells), N words of W bits each.
- Accepts write requests over a valid/ready handshake and drives each latch word's shared data bus and per-word enable.
- Each write uses a timed sequence: data setup, enable pulse, data hold.
- Reads back the addressed word's q after the pulse and flags any mismatch, so the latch array can be exercised and checked from synchronous logic.

Parameters:
- W, 4, data width of one latch word
- N, 4, number of latch words; address width AW = clog2(N), minimum 1
- SETUP, 1, cycles lat_d is stable before lat_en rises (range 1..15)
- PULSE, 2, cycles lat_en stays high (range 1..15)
- HOLD, 1, cycles lat_d stays stable after lat_en falls (range 0..15)

Ports:
- clk, input, 1, single clock, rising edge
- rst, input, 1, reset, asynchronous, active-high
- wr_valid, input, 1, write request present
- wr_ready, output, 1, block can accept a request
- wr_addr, input, AW, target latch word
- wr_data, input, W, value to store
- lat_d, output, W, shared data bus to all latch d inputs
- lat_en, output, N, per-word latch enable, one-hot or zero
- lat_q, input, N*W, concatenated latch q outputs; word i is bits [i*W +: W]
- done, output, 1, one-cycle pulse when a write sequence completes
- err, output, 1, sticky error flag
- err_clr, input, 1, clears err

Behaviour:
- Reset (async, immediate): state=IDLE, wr_ready=1, lat_en=0, lat_d=0, done=0, err=0, all counters=0. lat_en drops the instant rst rises, even mid-pulse; a latch interrupted this way holds undefined content, and the block does not retry.
- Handshake: a request is accepted on a rising edge with wr_valid && wr_ready. wr_ready=1 only in IDLE. Address and data are captured into internal registers at acceptance; the requester may change its inputs afterwards.
- IDLE -> SETUP on accept:
  - lat_d <= captured data in the same edge.
  - If wr_addr >= N: set err, pulse done, stay in IDLE. No enable is driven.
- SETUP: cnt counts SETUP cycles, then -> PULSE.
  - lat_en[addr] rises exactly SETUP cycles after the accept edge.
- PULSE: lat_en[addr]=1 for exactly PULSE cycles, then all lat_en=0 -> HOLD. Never more than one lat_en bit high.
- HOLD: lat_d unchanged for HOLD cycles (HOLD=0 skips this state), then -> CHECK.
- CHECK: one cycle.
  - Compare lat_q word[addr] against captured data; if they differ, set err.
  - Pulse done; -> IDLE (wr_ready=1 the next cycle).
- Latency, accept edge to done: SETUP+PULSE+HOLD+1 cycles. With defaults: 5.
- lat_d keeps its last value in IDLE; it is not cleared.
- err is sticky.
  - err_clr clears it on the next edge.
  - If err_clr and a new error coincide in the same cycle, the error wins (err stays 1).
- wr_valid held high continuously: one request accepted per sequence; the next is accepted on the edge after done.
- Counters are 4 bits wide and saturate; they never wrap.

Decomposition:
- Shared package latch_pkg:
  - state enum: IDLE, SETUP, PULSE, HOLD, CHECK
  - clog2 helper function
  - default timing constants
- Sub-module: timing sequencer latch_seq_fsm, holding the state register, counter and lat_en decode.
- The top level holds the handshake/capture registers, the readback mux and the err logic.
- The bench instantiates N dlatches cells on lat_d/lat_en[i], feeding lat_q.

Test Plan:
- Reset then single write (addr=2, data=4'hA, defaults): lat_d=A on the accept edge; lat_en=4'b0100 for exactly 2 cycles starting 1 cycle after accept; done 5 cycles after accept; err=0; lat_q word2=A.
- Back-to-back writes with wr_valid held high (addr0=5, addr1=3): second accept occurs the cycle after the first done; words 0 and 1 read 5 and 3; lat_en is never 2 bits high.
- Readback fault (bench forces lat_q word1 stuck at 0, write addr=1, data=F): err=1 after CHECK. With err_clr pulsed the next cycle: err=0. With err_clr pulsed coincident with a new fault: err stays 1.
- Out-of-range address (N=3, write addr=3): no lat_en bit rises; err=1; done pulses on the edge after accept; wr_ready stays 1.
- Reset asserted mid-PULSE: lat_en=0 and wr_ready=1 immediately (before the next clk edge); after release, a new write to the same address completes normally.
- Timing parameters SETUP=3, PULSE=1, HOLD=0: lat_en rises 3 cycles after accept, is high for 1 cycle; done 5 cycles after accept; HOLD state never entered.

Source files
------------

// File: rtl/latch_pkg.sv
// Shared types, timing defaults and helpers for the latch bank writer.
package latch_pkg;

  // Write-sequence phases.
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    CHECK
  } seq_state_e;

  // Default geometry and timing.
  localparam int DEF_W     = 4;
  localparam int DEF_N     = 4;
  localparam int DEF_SETUP = 1;
  localparam int DEF_PULSE = 2;
  localparam int DEF_HOLD  = 1;

  // Phase counters are 4 bits and saturate.
  localparam int CNT_W = 4;

  // Ceiling log2, never below 1 so a single-word bank still has an address bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/latch_seq_fsm.sv
// Timing sequencer: walks SETUP -> PULSE -> HOLD -> CHECK and decodes the
// one-hot latch enable while in PULSE.
module latch_seq_fsm
  import latch_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int AW        = clog2(DEF_N),
  parameter int SETUP_CYC = DEF_SETUP,
  parameter int PULSE_CYC = DEF_PULSE,
  parameter int HOLD_CYC  = DEF_HOLD
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] addr,
  output logic          idle,
  output logic          check,
  output logic [N-1:0]  lat_en
);

  // Last count value of each phase; counting starts at 0 on phase entry.
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);

  seq_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;

  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  // State and phase counter; reset drops back to IDLE at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, counter and decoded outputs. lat_en comes straight from the
  // state register so an async reset kills the pulse without waiting for clk.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_inc;
    idle      = 1'b0;
    check     = 1'b0;
    lat_en    = '0;
    case (state)
      IDLE: begin
        idle    = 1'b1;
        cnt_nxt = '0;
        if (start) state_nxt = SETUP;
      end
      SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_nxt = PULSE;
          cnt_nxt   = '0;
        end
      end
      PULSE: begin
        for (int i = 0; i < N; i++) lat_en[i] = (addr == AW'(i));
        if (cnt == PULSE_LAST) begin
          state_nxt = (HOLD_CYC == 0) ? CHECK : HOLD;
          cnt_nxt   = '0;
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = CHECK;
          cnt_nxt   = '0;
        end
      end
      CHECK: begin
        check     = 1'b1;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/latch_bank_writer.sv
// Write controller for a bank of gated D latches: handshake, capture,
// timed enable pulse via the sequencer, readback check and sticky error.
module latch_bank_writer
  import latch_pkg::*;
#(
  parameter int  W     = DEF_W,
  parameter int  N     = DEF_N,
  parameter int  SETUP = DEF_SETUP,
  parameter int  PULSE = DEF_PULSE,
  parameter int  HOLD  = DEF_HOLD,
  localparam int AW    = clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_valid,
  output logic           wr_ready,
  input  logic [AW-1:0]  wr_addr,
  input  logic [W-1:0]   wr_data,
  output logic [W-1:0]   lat_d,
  output logic [N-1:0]   lat_en,
  input  logic [N*W-1:0] lat_q,
  output logic           done,
  output logic           err,
  input  logic           err_clr
);

  logic          idle, check, accept, addr_ok, err_set;
  logic [AW-1:0] addr_q;
  logic [W-1:0]  q_word;

  assign wr_ready = idle;
  assign accept   = wr_valid && wr_ready;

  // Only a non-power-of-two bank can see an address past its last word.
  if (N == (1 << AW)) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_part
    assign addr_ok = (wr_addr < AW'(N));
  end

  latch_seq_fsm #(
    .N        (N),
    .AW       (AW),
    .SETUP_CYC(SETUP),
    .PULSE_CYC(PULSE),
    .HOLD_CYC (HOLD)
  ) u_fsm (
    .clk   (clk),
    .rst   (rst),
    .start (accept && addr_ok),
    .addr  (addr_q),
    .idle  (idle),
    .check (check),
    .lat_en(lat_en)
  );

  // Select the addressed word of the latch outputs for readback.
  always_comb begin
    q_word = '0;
    for (int i = 0; i < N; i++)
      if (addr_q == AW'(i)) q_word = lat_q[i*W +: W];
  end

  // lat_d doubles as the captured write data: it only changes on accept.
  assign err_set = (check && (q_word != lat_d)) || (accept && !addr_ok);

  // Capture registers, done pulse and sticky error (a new error beats clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_d  <= '0;
      addr_q <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= check || (accept && !addr_ok);
      if (accept) begin
        lat_d  <= wr_data;
        addr_q <= wr_addr;
      end
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_latch_bank_writer.sv
// Directed bench: default bank with latch models (A), 3-word bank for the
// out-of-range case (B), and SETUP=3/PULSE=1/HOLD=0 timing (C).
module tb_latch_bank_writer;
  import latch_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // ---- DUT A: defaults, N=4 ----
  logic         a_valid, a_ready, a_done, a_err, a_clr;
  logic [1:0]   a_addr;
  logic [W-1:0] a_data, a_d;
  logic [3:0]   a_en;
  logic [4*W-1:0] a_q;
  logic         fault1;

  latch_bank_writer dut_a (
    .clk(clk), .rst(rst), .wr_valid(a_valid), .wr_ready(a_ready),
    .wr_addr(a_addr), .wr_data(a_data), .lat_d(a_d), .lat_en(a_en),
    .lat_q(a_q), .done(a_done), .err(a_err), .err_clr(a_clr)
  );

  for (genvar i = 0; i < 4; i++) begin : g_a_lat
    logic [W-1:0] m;
    always_latch if (a_en[i]) m <= a_d;
    assign a_q[i*W +: W] = (fault1 && i == 1) ? '0 : m;
  end

  // ---- DUT B: N=3 ----
  logic         b_valid, b_ready, b_done, b_err, b_clr;
  logic [1:0]   b_addr;
  logic [W-1:0] b_data, b_d;
  logic [2:0]   b_en;
  logic [3*W-1:0] b_q;
  assign b_q = '0;

  latch_bank_writer #(.N(3)) dut_b (
    .clk(clk), .rst(rst), .wr_valid(b_valid), .wr_ready(b_ready),
    .wr_addr(b_addr), .wr_data(b_data), .lat_d(b_d), .lat_en(b_en),
    .lat_q(b_q), .done(b_done), .err(b_err), .err_clr(b_clr)
  );

  // ---- DUT C: SETUP=3, PULSE=1, HOLD=0 ----
  logic         c_valid, c_ready, c_done, c_err, c_clr;
  logic [1:0]   c_addr;
  logic [W-1:0] c_data, c_d;
  logic [3:0]   c_en;
  logic [4*W-1:0] c_q;

  latch_bank_writer #(.SETUP(3), .PULSE(1), .HOLD(0)) dut_c (
    .clk(clk), .rst(rst), .wr_valid(c_valid), .wr_ready(c_ready),
    .wr_addr(c_addr), .wr_data(c_data), .lat_d(c_d), .lat_en(c_en),
    .lat_q(c_q), .done(c_done), .err(c_err), .err_clr(c_clr)
  );

  for (genvar i = 0; i < 4; i++) begin : g_c_lat
    logic [W-1:0] m;
    always_latch if (c_en[i]) m <= c_d;
    assign c_q[i*W +: W] = m;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps DUT A until done, checking lat_en stays one-hot or zero.
  task automatic run_a(output int n);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("a_en_onehot", 32'($countones(a_en) <= 1), 32'd1);
      if (a_done) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n;
    logic hold_seen;
    a_valid = 0; a_addr = 0; a_data = 0; a_clr = 0; fault1 = 0;
    b_valid = 0; b_addr = 0; b_data = 0; b_clr = 0;
    c_valid = 0; c_addr = 0; c_data = 0; c_clr = 0;

    // Reset state
    #12;
    chk("rst_ready", a_ready, 1);
    chk("rst_en",    a_en,    0);
    chk("rst_lat_d", a_d,     0);
    chk("rst_done",  a_done,  0);
    chk("rst_err",   a_err,   0);
    chk("rst_b_ready", b_ready, 1);
    chk("rst_c_en",  c_en,    0);
    rst = 0;

    // Single write addr=2 data=A
    a_valid = 1; a_addr = 2; a_data = 4'hA;
    step();
    chk("w1_lat_d", a_d, 4'hA);
    chk("w1_ready", a_ready, 0);
    chk("w1_en0",   a_en, 0);
    a_valid = 0; a_addr = 0; a_data = 0;
    step(); chk("w1_en1", a_en, 4'b0100); chk("w1_done1", a_done, 0);
    step(); chk("w1_en2", a_en, 4'b0100);
    step(); chk("w1_en3", a_en, 4'b0000); chk("w1_done3", a_done, 0);
    step(); chk("w1_done4", a_done, 0); chk("w1_lat_d_hold", a_d, 4'hA);
    step();
    chk("w1_done5", a_done, 1);
    chk("w1_err",   a_err, 0);
    chk("w1_ready5", a_ready, 1);
    chk("w1_word2", a_q[2*W +: W], 4'hA);
    step(); chk("w1_done6", a_done, 0);

    // Back-to-back with wr_valid held high
    a_valid = 1; a_addr = 0; a_data = 4'h5;
    step();
    a_addr = 1; a_data = 4'h3;
    run_a(n); chk("b2b_lat1", n, 5);
    step();
    chk("b2b_acc_ready", a_ready, 0);
    chk("b2b_acc_lat_d", a_d, 4'h3);
    a_valid = 0;
    run_a(n); chk("b2b_lat2", n, 5);
    chk("b2b_word0", a_q[0 +: W], 4'h5);
    chk("b2b_word1", a_q[W +: W], 4'h3);
    chk("b2b_err", a_err, 0);

    // Readback fault on word 1, then clear
    fault1 = 1;
    a_valid = 1; a_addr = 1; a_data = 4'hF;
    step();
    a_valid = 0;
    run_a(n); chk("flt_lat", n, 5);
    chk("flt_err", a_err, 1);
    a_clr = 1; step(); a_clr = 0;
    chk("flt_clr", a_err, 0);

    // Clear coincident with a new fault: error wins
    a_valid = 1; a_addr = 1; a_data = 4'hF;
    step();
    a_valid = 0;
    step(); step(); step(); step();
    a_clr = 1;
    step();
    a_clr = 0;
    chk("flt2_done", a_done, 1);
    chk("flt2_err_wins", a_err, 1);
    step(); chk("flt2_sticky", a_err, 1);
    a_clr = 1; step(); a_clr = 0;
    chk("flt2_clr", a_err, 0);
    fault1 = 0;

    // Reset in the middle of PULSE
    a_valid = 1; a_addr = 3; a_data = 4'h6;
    step();
    a_valid = 0;
    step(); chk("mid_en", a_en, 4'b1000);
    #2 rst = 1;
    #1;
    chk("mid_rst_en", a_en, 0);
    chk("mid_rst_ready", a_ready, 1);
    chk("mid_rst_done", a_done, 0);
    #2 rst = 0;
    a_valid = 1; a_addr = 3; a_data = 4'h9;
    step();
    a_valid = 0;
    run_a(n); chk("mid_lat", n, 5);
    chk("mid_err", a_err, 0);
    chk("mid_word3", a_q[3*W +: W], 4'h9);

    // Out-of-range address on N=3 bank
    b_valid = 1; b_addr = 3; b_data = 4'h7;
    step();
    chk("oor_en",    b_en, 0);
    chk("oor_err",   b_err, 1);
    chk("oor_done",  b_done, 1);
    chk("oor_ready", b_ready, 1);
    b_valid = 0;
    step();
    chk("oor_done_end", b_done, 0);
    chk("oor_err_sticky", b_err, 1);
    chk("oor_en2", b_en, 0);

    // SETUP=3, PULSE=1, HOLD=0
    hold_seen = 0;
    c_valid = 1; c_addr = 1; c_data = 4'hC;
    step();
    c_valid = 0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("c_en_%0d", k), c_en, (k == 3) ? 4'b0010 : 4'b0000);
      chk($sformatf("c_done_%0d", k), c_done, (k == 5) ? 1 : 0);
      if (dut_c.u_fsm.state == HOLD) hold_seen = 1;
    end
    chk("c_no_hold", hold_seen, 0);
    chk("c_err", c_err, 0);
    chk("c_word1", c_q[W +: W], 4'hC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
